fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage of the pipelined RV32I core.
- Owns the PC, issues reads to the instruction cache, and buffers returned instructions in a small queue.
- Presents {pc, instr} to the decode stage, whose control ROM decodes opcode/funct3/funct7 from instr.
- Handles decode back-pressure (stall) and control-flow redirects from the branch/jump resolution stage.

Parameters:
- RESET_PC, 32'h00000060, PC of the first fetch after reset.
- QDEPTH, 2, fetch queue entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_address  out  32  fetch address, word aligned
- imem_read  out  1  read request; held with a stable address until imem_resp
- imem_rdata  in  32  instruction word, valid when imem_resp=1
- imem_resp  in  1  one-cycle completion pulse for the outstanding read
- redirect  in  1  taken branch/jal/jalr; flush and refetch
- redirect_pc  in  32  target PC when redirect=1
- stall  in  1  decode not ready; head entry is held
- if_valid  out  1  head entry valid
- if_pc  out  32  PC of head entry
- if_instr  out  32  instruction of head entry (opcode=[6:0], funct3=[14:12], funct7=[31:25])
- if_misalign  out  1  sticky misaligned-target flag (optional feature only; tie 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: fetch_pc=RESET_PC; queue empty; if_valid=0; if_pc=0; if_instr=0; imem_read=0; if_misalign=0; state=IDLE.
- First request: imem_read rises in the first cycle after rst deasserts, with imem_address=RESET_PC.
- State machine:
  - IDLE -> REQ when the queue has a free slot counting the in-flight request.
  - REQ: imem_read=1, imem_address=fetch_pc.
  - REQ + imem_resp -> push {fetch_pc, imem_rdata}; fetch_pc += 4.
    - Next state is REQ if a slot remains, else IDLE.
    - Back-to-back requests are allowed: imem_read may stay high across a resp.
  - REQ + redirect (no resp this cycle) -> DROP.
    - The address and read stay stable, as the cache protocol requires.
  - DROP: imem_read=1 with the old address. On imem_resp, discard the data and go to REQ with fetch_pc=target.
- Redirect handling:
  - redirect has priority over every other event in the same cycle.
  - Queue is flushed; if_valid=0 the next cycle.
  - fetch_pc <= redirect_pc.
  - Redirect coincident with imem_resp: the response is discarded, nothing is pushed, and the new request issues the next cycle.
  - Redirect in IDLE: go to REQ the next cycle.
  - Redirect in DROP: update the target only and stay in DROP.
- Queue:
  - Head is driven combinationally from storage.
  - Pop when if_valid && !stall.
  - Push and pop in the same cycle are allowed, including when the queue is full.
  - Pointers wrap mod QDEPTH.
  - Full: no new request issued.
  - Empty: if_valid=0; if_pc and if_instr hold their last values.
- Latency: imem_resp in cycle N -> if_valid=1 in cycle N+1 with that instruction, if the queue was empty.
- Stall: if_pc and if_instr stay unchanged while stall=1 and if_valid=1.
- PC arithmetic: 32-bit and wraps; 32'hFFFFFFFC + 4 = 0.
- rst asserted mid-request: state returns to IDLE at once. A later stale imem_resp is ignored. The cache must drop the stale request when imem_read falls.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - redirect with redirect_pc[1:0]!=0 sets if_misalign=1 (sticky until rst).
  - Queue is flushed and fetch halts: no further imem_read.
  - if_valid stays 0.
- Undefined:
  - if_misalign is tied 0.
  - redirect_pc[1:0] is forced to 2'b00 before it is loaded into fetch_pc.

Test Plan:
- Reset release, cache returns 1-cycle resp with imem_rdata=32'h00000013 -> first imem_address=0x60; if_valid=1, if_pc=0x60, if_instr=0x13 one cycle after resp; next request at 0x64.
- stall=1 held 5 cycles with QDEPTH=2 -> after 2 pushes, imem_read stays 0; if_pc=0x60 stable throughout; stall=0 pops 0x60, then 0x64.
- redirect=1, redirect_pc=0x200 while a read of 0x68 is outstanding (resp 3 cycles later) -> imem_address stays 0x68 until resp; data discarded; next request at 0x200; first if_pc=0x200.
- redirect coincident with imem_resp for 0x64 -> 0x64 never appears on if_pc; queue empty next cycle; request 0x200 the following cycle.
- Redirect to 0xFFFFFFFC -> fetches 0xFFFFFFFC, then 0x00000000.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x102 -> if_misalign=1 next cycle, imem_read=0 permanently, if_valid=0. Without the macro -> fetch at 0x100.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage of the pipelined RV32I core. Owns the fetch PC,
//   issues word reads to the instruction cache, buffers returned instructions
//   in a QDEPTH-entry queue and presents the head entry {pc, instr} to decode.
//   Control-flow redirects flush the queue and restart fetch at the target.
//
//   Optional feature macro: FETCH_MISALIGN_TRAP_EN
//     defined   : a redirect to a non-word-aligned target sets the sticky
//                 if_misalign flag, flushes the queue and halts fetch until rst.
//     undefined : if_misalign is tied 0 and target bits [1:0] are cleared.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   imem_address    fetch address (word aligned), held stable while imem_read
//   imem_read       read request, held until imem_resp
//   imem_rdata      instruction word, valid with imem_resp
//   imem_resp       one-cycle completion pulse for the outstanding read
//   redirect        taken branch/jal/jalr: flush and refetch at redirect_pc
//   redirect_pc     redirect target
//   stall           decode not ready; head entry is held
//   if_valid        head entry valid
//   if_pc, if_instr head entry (hold last shown values while empty)
//   if_misalign     sticky misaligned-target flag (optional feature)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000060,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drop_addr_q, drop_addr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [31:0]   last_pc_q, last_instr_q;
  logic          push, pop;
  logic          misalign_hit;
  logic [31:0]   target_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_hit = (redirect_pc[1:0] != 2'b00);
  assign target_pc    = redirect_pc;
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign misalign_hit   = 1'b0;
  assign target_pc      = {redirect_pc[31:2], 2'b00};
`endif

  // Head of queue, driven straight from storage; while empty the last shown
  // entry is replayed so decode sees stable values.
  assign if_valid = (count_q != '0);
  assign if_pc    = if_valid ? q_pc[rd_ptr_q]    : last_pc_q;
  assign if_instr = if_valid ? q_instr[rd_ptr_q] : last_instr_q;
  assign pop      = if_valid && !stall;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drop_addr_d  = drop_addr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    push         = 1'b0;
    imem_read    = 1'b0;
    imem_address = fetch_pc_q;

    case (state_q)
      REQ:  imem_read = 1'b1;
      DROP: begin
        imem_read    = 1'b1;
        imem_address = drop_addr_q;
      end
      default: ;
    endcase

    if (redirect && state_q != HALT) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (misalign_hit) begin
        state_d = HALT;
      end else begin
        fetch_pc_d = target_pc;
        case (state_q)
          IDLE: state_d = REQ;
          REQ: begin
            if (imem_resp) begin
              state_d = REQ;
            end else begin
              // Read must finish at its original address; fetch_pc already
              // holds the new target, so the old address is parked here.
              state_d     = DROP;
              drop_addr_d = fetch_pc_q;
            end
          end
          // A response arriving together with a new redirect retires the
          // dropped read, so fetch can restart rather than wait forever.
          DROP: state_d = imem_resp ? REQ : DROP;
          default: ;
        endcase
      end
    end else begin
      push     = (state_q == REQ) && imem_resp;
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      case (state_q)
        IDLE: if (count_q < QFULL) state_d = REQ;
        REQ: begin
          if (imem_resp) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            // Keep requesting only if a slot is still free for the next read.
            if (count_d >= QFULL) state_d = IDLE;
          end
        end
        DROP: if (imem_resp) state_d = REQ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      drop_addr_q  <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      last_pc_q    <= '0;
      last_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      if (if_valid) begin
        last_pc_q    <= if_pc;
        last_instr_q <= if_instr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_pc[wr_ptr_q]    <= fetch_pc_q;
      q_instr[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (state_d == HALT) begin
      misalign_q <= 1'b1;
    end
  end
  assign if_misalign = misalign_q;
`else
  assign if_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Scoreboard bench for fetch_stage. The expected instruction stream is the
//   sequence target, target+4, ... restarted at every redirect/reset; the
//   stimulus process keeps that sequence queued, a monitor compares the head
//   entry against it and pops on every accepted instruction. A cache model
//   answers reads with random latency and returns a fixed function of the
//   address as instruction data.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h00000060;
  localparam int unsigned QDEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  fetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_address(imem_address), .imem_read(imem_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_misalign(if_misalign)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          deliveries = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_next = RESET_PC;
  int unsigned epoch = 0;
  int unsigned lat_min = 0, lat_max = 0;

  // cache model state
  logic        busy = 1'b0;
  logic [31:0] addr_q = '0;
  int unsigned wait_left = 0;
  int unsigned req_epoch = 0, resp_epoch = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h00000013;
  endfunction

  function automatic logic [31:0] target_of(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0:       t = 32'hFFFFFFF0 + 32'($urandom_range(0, 3) * 4);
      1:       t = 32'h00000100 + 32'($urandom_range(0, 63) * 4);
      default: t = $urandom & 32'hFFFFFFFC;
    endcase
`ifndef FETCH_MISALIGN_TRAP_EN
    if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
`endif
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    redirect = 1'b0;
    topup();
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    exp_q.delete();
    exp_next = target_of(t);
    topup();
    #1;
    epoch++;
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst      = 1'b1;
    redirect = 1'b0;
    exp_q.delete();
    exp_next = RESET_PC;
    topup();
    epoch++;
    repeat (cycles) tick();
  endtask

  // Cache model: captures a new read, holds it for a random latency, checks
  // the address stays stable meanwhile, and drops it if imem_read falls.
  initial begin
    imem_resp  = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_resp = 1'b0;
      if (rst || !imem_read) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy      = 1'b1;
          addr_q    = imem_address;
          req_epoch = epoch;
          wait_left = $urandom_range(lat_min, lat_max);
        end else begin
          check("addr_stable", imem_address, addr_q);
        end
        if (wait_left == 0) begin
          imem_resp  = 1'b1;
          imem_rdata = instr_of(addr_q);
          resp_epoch = req_epoch;
          busy       = 1'b0;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Monitor / scoreboard
  logic prev_redir = 1'b0, lat_pending = 1'b0, saw_wrap = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_redir)  check("flush_valid", 32'(if_valid), 32'd0);
      if (lat_pending) check("resp_latency", 32'(if_valid), 32'd1);
      if (!redirect && if_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty got=%h want=none", if_pc);
        end else begin
          check("head_pc", if_pc, exp_q[0]);
          check("head_instr", if_instr, instr_of(exp_q[0]));
          if (!stall) begin
            if (exp_q[0] == 32'd0) saw_wrap = 1'b1;
            void'(exp_q.pop_front());
            deliveries++;
          end
        end
      end
    end
    prev_redir  = redirect && !rst;
    lat_pending = imem_resp && !redirect && !rst && !if_valid && (resp_epoch == epoch);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    lat_min = 0; lat_max = 0;

    // Reset values
    stall = 1'b1;
    do_reset(3);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_imem_read", 32'(imem_read), 32'd0);
    check("rst_if_misalign", 32'(if_misalign), 32'd0);

    // First request after reset release, then fill queue under stall
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      if (imem_read) begin found = 1'b1; break; end
    end
    check("first_req_seen", 32'(found), 32'd1);
    check("first_req_addr", imem_address, RESET_PC);
    repeat (10) tick();
    #1;
    check("full_no_req", 32'(imem_read), 32'd0);
    check("stall_valid", 32'(if_valid), 32'd1);
    check("stall_pc", if_pc, RESET_PC);
    stall = 1'b0;
    repeat (6) tick();

    // Redirect while a read is outstanding
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      if (busy) begin found = 1'b1; do_redirect(32'h00000200); break; end
    end
    check("outstanding_seen", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      if (imem_resp) begin found = 1'b1; break; end
    end
    check("drop_resp_seen", 32'(found), 32'd1);
    tick(); #1;
    check("after_drop_read", 32'(imem_read), 32'd1);
    check("after_drop_addr", imem_address, 32'h00000200);
    repeat (12) tick();

    // Redirect coincident with a response
    lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      if (imem_resp) begin found = 1'b1; do_redirect(32'h00000300); break; end
    end
    check("coincident_seen", 32'(found), 32'd1);
    tick(); #1;
    check("coincident_read", 32'(imem_read), 32'd1);
    check("coincident_addr", imem_address, 32'h00000300);
    repeat (8) tick();

    // PC wrap
    lat_min = 0; lat_max = 0;
    do_redirect(32'hFFFFFFFC);
    repeat (20) tick();
    check("wrap_seen", 32'(saw_wrap), 32'd1);

    // Misaligned redirect target
    do_redirect(32'h00000102);
`ifdef FETCH_MISALIGN_TRAP_EN
    tick();
    check("misalign_flag", 32'(if_misalign), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_no_read", 32'(imem_read), 32'd0);
      check("halt_no_valid", 32'(if_valid), 32'd0);
    end
    do_reset(2);
    rst = 1'b0;
`else
    repeat (10) tick();
    check("misalign_tied0", 32'(if_misalign), 32'd0);
`endif

    // Randomized traffic
    lat_min = 0; lat_max = 3;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      stall = ($urandom_range(0, 99) < 30);
      if (cyc == 1500) begin
        do_reset(2);
        rst = 1'b0;
      end else if ($urandom_range(0, 99) < 4) begin
        do_redirect(rand_target());
      end
    end
    stall = 1'b0;
    repeat (10) tick();

    check("deliveries", 32'(deliveries >= 200), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
